// File: rtl/lsu_ctrl_if.sv
// Request/response and data-memory bus of the load/store unit.
// The master view is the pipeline plus memory side; the slave view is lsu_ctrl.
interface lsu_ctrl_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              misalign_err;
    logic              range_err;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic              dmem_read;
    logic              dmem_write;
    logic [31:0]       dmem_rdata;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output dmem_rdata,
        input  req_ready, resp_valid, resp_rdata, misalign_err, range_err,
        input  dmem_addr, dmem_wdata, dmem_read, dmem_write
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  dmem_rdata,
        output req_ready, resp_valid, resp_rdata, misalign_err, range_err,
        output dmem_addr, dmem_wdata, dmem_read, dmem_write
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit: one request at a time, alignment/range checks, sub-word
// load extraction and read-modify-write for sub-word stores to a word memory.
module lsu_ctrl #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic      clk,
    input  logic      rst_n,
    lsu_ctrl_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_RD,
        ST_WRITE
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        size;
        logic              write;
        logic              is_unsigned;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_e            state_q, state_d;
    req_t              req_q, req_d;
    logic [DATA_W-1:0] merge_q, merge_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              misalign_q, misalign_d;
    logic              range_q, range_d;

    logic              misalign_c;
    logic              range_c;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merge_data;

    // Request legality, evaluated on the incoming (unlatched) request
    always_comb begin
        misalign_c = 1'b1;
        case (bus.req_size)
            SZ_BYTE: misalign_c = 1'b0;
            SZ_HALF: misalign_c = bus.req_addr[0];
            SZ_WORD: misalign_c = |bus.req_addr[1:0];
            default: misalign_c = 1'b1;
        endcase
        range_c = |bus.req_addr[DATA_W-1:ADDR_W];
    end

    // Lane extraction for loads and lane replacement for read-modify-write
    always_comb begin
        lane_b    = bus.dmem_rdata[{req_q.addr[1:0], 3'b000} +: 8];
        lane_h    = bus.dmem_rdata[{req_q.addr[1], 4'b0000} +: 16];
        load_data = bus.dmem_rdata;
        case (req_q.size)
            SZ_BYTE: load_data = {{24{~req_q.is_unsigned & lane_b[7]}}, lane_b};
            SZ_HALF: load_data = {{16{~req_q.is_unsigned & lane_h[15]}}, lane_h};
            default: load_data = bus.dmem_rdata;
        endcase

        merge_data = bus.dmem_rdata;
        if (req_q.size == SZ_BYTE) begin
            merge_data[{req_q.addr[1:0], 3'b000} +: 8] = req_q.wdata[7:0];
        end else begin
            merge_data[{req_q.addr[1], 4'b0000} +: 16] = req_q.wdata[15:0];
        end
    end

    // Next-state and response logic
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        merge_d      = merge_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        misalign_d   = misalign_q;
        range_d      = range_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    req_d.addr        = bus.req_addr[ADDR_W-1:0];
                    req_d.size        = bus.req_size;
                    req_d.write       = bus.req_write;
                    req_d.is_unsigned = bus.req_unsigned;
                    req_d.wdata       = bus.req_wdata;
                    if (misalign_c || range_c) begin
                        resp_valid_d = 1'b1;
                        misalign_d   = misalign_c;
                        range_d      = range_c;
                    end else if (!bus.req_write) begin
                        state_d = ST_LOAD;
                    end else if (bus.req_size == SZ_WORD) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_LOAD: begin
                resp_rdata_d = load_data;
                resp_valid_d = 1'b1;
                misalign_d   = 1'b0;
                range_d      = 1'b0;
                state_d      = ST_IDLE;
            end
            ST_RMW_RD: begin
                merge_d = merge_data;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                resp_valid_d = 1'b1;
                misalign_d   = 1'b0;
                range_d      = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            merge_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            misalign_q   <= 1'b0;
            range_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            merge_q      <= merge_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            misalign_q   <= misalign_d;
            range_q      <= range_d;
        end
    end

    // Memory strobes decode straight from the state flop so reset kills them at once
    assign bus.req_ready    = (state_q == ST_IDLE);
    assign bus.dmem_read    = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
    assign bus.dmem_write   = (state_q == ST_WRITE);
    assign bus.dmem_addr    = (state_q == ST_IDLE) ? '0 : {req_q.addr[ADDR_W-1:2], 2'b00};
    assign bus.dmem_wdata   = (state_q != ST_WRITE) ? '0 :
                              (req_q.write && req_q.size == SZ_WORD) ? req_q.wdata : merge_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.misalign_err = misalign_q;
    assign bus.range_err    = range_q;

endmodule
